axi_slave_responder: RTL and testbench

AXI4 slave endpoint that terminates write (AW/W/B) and read (AR/R) traffic from an AXI master, backed by an internal byte-strobed 64-bit word memory. It answers the handshakes that the master-side protocol FSMs drive: accepts addresses and write data, generates write responses, and streams read bursts with correct RLAST. One outstanding transaction per direction; write and read paths run independently and concurrently.

---
 rtl/axi_slave_pkg.sv | 29 ++
 rtl/axi_burst_addr.sv | 23 ++
 rtl/axi_slave_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_slave_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared constants, FSM state types and response helpers for the AXI4 slave responder.
package axi_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

    // Request-level protocol errors: unsupported WRAP, reserved burst, or size wider than the bus.
    function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd3);
    endfunction

    function automatic logic [1:0] resp_of(input logic decerr, input logic slverr);
        if (decerr)
            return RESP_DECERR;
        if (slverr)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address: FIXED holds, INCR aligns to the beat size then steps.
module axi_burst_addr
    import axi_slave_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] step;

    // Non-INCR bursts keep their address; WRAP is rejected as SLVERR upstream.
    always_comb begin
        step      = {{(AW-1){1'b0}}, 1'b1} << size;
        next_addr = addr;
        if (burst == BURST_INCR)
            next_addr = (addr & ~(step - 1'b1)) + step;
    end

endmodule

// File: rtl/axi_slave_responder.sv
// AXI4 slave endpoint over a byte-strobed 64-bit word memory; independent write and read paths,
// one outstanding transaction per direction.
module axi_slave_responder
    import axi_slave_pkg::*;
#(
    parameter int IDW   = 12,
    parameter int AW    = 32,
    parameter int DEPTH = 256
) (
    input  logic           axi_aclk,
    input  logic           rst,
    input  logic [IDW-1:0] awid,
    input  logic [AW-1:0]  awaddr,
    input  logic [7:0]     awlen,
    input  logic [2:0]     awsize,
    input  logic [1:0]     awburst,
    input  logic           awvalid,
    output logic           awready,
    input  logic [63:0]    wdata,
    input  logic [7:0]     wstrb,
    input  logic           wlast,
    input  logic           wvalid,
    output logic           wready,
    output logic [IDW-1:0] bid,
    output logic [1:0]     bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [IDW-1:0] arid,
    input  logic [AW-1:0]  araddr,
    input  logic [7:0]     arlen,
    input  logic [2:0]     arsize,
    input  logic [1:0]     arburst,
    input  logic           arvalid,
    output logic           arready,
    output logic [IDW-1:0] rid,
    output logic [63:0]    rdata,
    output logic [1:0]     rresp,
    output logic           rlast,
    output logic           rvalid,
    input  logic           rready
);

    localparam int IW = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];

    function automatic logic out_of_range(input logic [AW-1:0] a);
        return a[AW-1:IW+3] != '0;
    endfunction

    // ---------------- write path ----------------
    wr_state_t     wr_state, wr_state_nxt;
    logic [AW-1:0] wr_addr, wr_addr_nxt;
    logic [7:0]    wr_cnt;
    logic [2:0]    wr_size;
    logic [1:0]    wr_burst;
    logic          wr_req_err, wr_decerr, wr_last_err;
    logic          w_hs, w_oob, w_last_bad, w_en;

    axi_burst_addr #(.AW(AW)) u_wr_addr (
        .addr      (wr_addr),
        .size      (wr_size),
        .burst     (wr_burst),
        .next_addr (wr_addr_nxt)
    );

    assign w_hs       = wvalid && wready;
    assign w_oob      = out_of_range(wr_addr);
    assign w_last_bad = wlast != (wr_cnt == 8'd0);
    assign w_en       = w_hs && !w_oob && !wr_req_err;

    always_ff @(posedge axi_aclk) begin
        if (rst)
            wr_state <= WR_IDLE;
        else
            wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                awready = 1'b1;
                if (awvalid)
                    wr_state_nxt = WR_DATA;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid && wr_cnt == 8'd0)
                    wr_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready)
                    wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            bid         <= '0;
            bresp       <= RESP_OKAY;
            wr_addr     <= '0;
            wr_cnt      <= '0;
            wr_size     <= '0;
            wr_burst    <= '0;
            wr_req_err  <= 1'b0;
            wr_decerr   <= 1'b0;
            wr_last_err <= 1'b0;
        end else if (awvalid && awready) begin
            bid         <= awid;
            wr_addr     <= awaddr;
            wr_cnt      <= awlen;
            wr_size     <= awsize;
            wr_burst    <= awburst;
            wr_req_err  <= req_err(awburst, awsize);
            wr_decerr   <= 1'b0;
            wr_last_err <= 1'b0;
        end else if (w_hs) begin
            wr_addr     <= wr_addr_nxt;
            wr_cnt      <= wr_cnt - 8'd1;
            wr_decerr   <= wr_decerr | w_oob;
            wr_last_err <= wr_last_err | w_last_bad;
            if (wr_cnt == 8'd0)
                bresp <= resp_of(wr_decerr | w_oob, wr_req_err | wr_last_err | w_last_bad);
        end
    end

    // NOTE: the memory array has no reset; its contents must survive rst and a reset
    // loop over every word would not map onto block RAM.
    always_ff @(posedge axi_aclk) begin
        if (!rst && w_en) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i])
                    mem[wr_addr[IW+2:3]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t     rd_state, rd_state_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic [7:0]    rd_cnt;
    logic [2:0]    rd_size;
    logic [1:0]    rd_burst;
    logic          rd_req_err, rd_decerr;
    logic          ar_oob, ar_err, nxt_oob;

    axi_burst_addr #(.AW(AW)) u_rd_addr (
        .addr      (rd_addr),
        .size      (rd_size),
        .burst     (rd_burst),
        .next_addr (rd_addr_nxt)
    );

    assign ar_oob  = out_of_range(araddr);
    assign ar_err  = req_err(arburst, arsize);
    assign nxt_oob = out_of_range(rd_addr_nxt);

    always_ff @(posedge axi_aclk) begin
        if (rst)
            rd_state <= RD_IDLE;
        else
            rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rlast        = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                arready = 1'b1;
                if (arvalid)
                    rd_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = (rd_cnt == 8'd0);
                if (rready && rd_cnt == 8'd0)
                    rd_state_nxt = RD_IDLE;
            end
        endcase
    end

    // rdata is loaded one beat ahead, so a same-edge write to that word is seen only next burst.
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            rid        <= '0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            rd_addr    <= '0;
            rd_cnt     <= '0;
            rd_size    <= '0;
            rd_burst   <= '0;
            rd_req_err <= 1'b0;
            rd_decerr  <= 1'b0;
        end else if (arvalid && arready) begin
            rid        <= arid;
            rd_addr    <= araddr;
            rd_cnt     <= arlen;
            rd_size    <= arsize;
            rd_burst   <= arburst;
            rd_req_err <= ar_err;
            rd_decerr  <= ar_oob;
            rresp      <= resp_of(ar_oob, ar_err);
            rdata      <= (ar_oob || ar_err) ? '0 : mem[araddr[IW+2:3]];
        end else if (rvalid && rready && rd_cnt != 8'd0) begin
            rd_addr    <= rd_addr_nxt;
            rd_cnt     <= rd_cnt - 8'd1;
            rd_decerr  <= rd_decerr | nxt_oob;
            rresp      <= resp_of(rd_decerr | nxt_oob, rd_req_err);
            rdata      <= (nxt_oob || rd_req_err) ? '0 : mem[rd_addr_nxt[IW+2:3]];
        end
    end

endmodule

// File: tb/tb_axi_slave_responder.sv
// Randomized bench for axi_slave_responder: transaction-level reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_axi_slave_responder;

    localparam int IDW   = 12;
    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam logic [31:0] LIMIT = DEPTH * 8;

    logic           axi_aclk = 1'b0;
    logic           rst;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [7:0]     awlen, arlen, wstrb;
    logic [2:0]     awsize, arsize;
    logic [1:0]     awburst, arburst, bresp, rresp;
    logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rlast, rvalid, rready;
    logic [63:0]    wdata, rdata;

    axi_slave_responder #(.IDW(IDW), .AW(AW), .DEPTH(DEPTH)) dut (
        .axi_aclk(axi_aclk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; } r_beat_t;
    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_resp_t;

    logic [63:0]    mm [DEPTH];
    logic [31:0]    wq[$], rq[$];
    bit             wr_active, rd_active, wr_bad, wr_dec, wr_last_err, rd_bad, rd_dec;
    logic [IDW-1:0] wr_id, rd_id;
    logic [63:0]    rd_cur;
    r_beat_t        r_log[$];
    b_resp_t        b_log[$];
    int             w_beats;

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst);
        logic [31:0] step;
        step = 32'd1 << size;
        if (burst != 2'b01)
            return a;
        return a - (a % step) + step;
    endfunction

    function automatic bit m_bad(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'd3);
    endfunction

    function automatic logic [1:0] m_resp(input bit dec, input bit bad);
        return dec ? 2'b11 : (bad ? 2'b10 : 2'b00);
    endfunction

    function automatic logic [63:0] m_read(input logic [31:0] a, input bit bad);
        if (bad || a >= LIMIT)
            return 64'd0;
        return mm[a / 8];
    endfunction

    initial begin
        logic [31:0] a;
        forever begin
            @(negedge axi_aclk);
            if (rst) begin
                wr_active = 0;
                rd_active = 0;
                wq.delete();
                rq.delete();
            end else begin
                check("awready", awready, !wr_active);
                check("wready", wready, wr_active && wq.size() > 0);
                check("bvalid", bvalid, wr_active && wq.size() == 0);
                check("arready", arready, !rd_active);
                check("rvalid", rvalid, rd_active);
                if (wr_active && wq.size() == 0) begin
                    check("bid", bid, wr_id);
                    check("bresp", bresp, m_resp(wr_dec, wr_bad || wr_last_err));
                end
                if (rd_active) begin
                    check("rid", rid, rd_id);
                    check("rdata", rdata, rd_cur);
                    check("rresp", rresp, m_resp(rd_dec, rd_bad));
                    check("rlast", rlast, rq.size() == 1);
                end
                // Read side first: a load at this edge sees memory before this edge's write.
                if (!rd_active && arvalid) begin
                    rd_active = 1;
                    rd_id = arid;
                    rd_bad = m_bad(arburst, arsize);
                    a = araddr;
                    for (int i = 0; i <= int'(arlen); i++) begin
                        rq.push_back(a);
                        a = m_next(a, arsize, arburst);
                    end
                    rd_dec = rq[0] >= LIMIT;
                    rd_cur = m_read(rq[0], rd_bad);
                end else if (rd_active && rready) begin
                    r_log.push_back('{rdata, rresp, rlast});
                    void'(rq.pop_front());
                    if (rq.size() == 0) begin
                        rd_active = 0;
                    end else begin
                        rd_dec = rd_dec || (rq[0] >= LIMIT);
                        rd_cur = m_read(rq[0], rd_bad);
                    end
                end
                if (!wr_active && awvalid) begin
                    wr_active = 1;
                    wr_id = awid;
                    wr_bad = m_bad(awburst, awsize);
                    wr_dec = 0;
                    wr_last_err = 0;
                    a = awaddr;
                    for (int i = 0; i <= int'(awlen); i++) begin
                        wq.push_back(a);
                        a = m_next(a, awsize, awburst);
                    end
                end else if (wr_active && wq.size() > 0 && wvalid) begin
                    w_beats++;
                    a = wq.pop_front();
                    if (wlast != (wq.size() == 0))
                        wr_last_err = 1;
                    if (a >= LIMIT) begin
                        wr_dec = 1;
                    end else if (!wr_bad) begin
                        for (int b = 0; b < 8; b++)
                            if (wstrb[b])
                                mm[a / 8][8*b +: 8] = wdata[8*b +: 8];
                    end
                end else if (wr_active && wq.size() == 0 && bready) begin
                    b_log.push_back('{bid, bresp});
                    wr_active = 0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    bit          gaps;

    task automatic wait_hs(input int which, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 300) begin
            @(negedge axi_aclk);
            case (which)
                0:       seen = awready;
                1:       seen = wready;
                2:       seen = bvalid;
                default: seen = arready;
            endcase
            @(posedge axi_aclk);
            #1;
            n++;
        end
        if (!seen)
            check({"timeout_", name}, 64'(seen), 64'd1);
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at,
                            input int b_hold);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
        wait_hs(0, "aw");
        awvalid = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    wvalid = 0;
                    @(posedge axi_aclk);
                    #1;
                end
            end
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
            wait_hs(1, "w");
        end
        wvalid = 0;
        wlast  = 0;
        bready = 0;
        wait_hs(2, "bvalid");
        repeat (b_hold) begin
            @(posedge axi_aclk);
            #1;
        end
        bready = 1;
        wait_hs(2, "b");
        bready = 0;
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
        int n;
        bit done;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
        wait_hs(3, "ar");
        arvalid = 0;
        n = 0;
        done = 0;
        while (!done && n < 2000) begin
            rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? n[0] : 1'($urandom_range(0, 1));
            @(negedge axi_aclk);
            done = rvalid && rready && rlast;
            @(posedge axi_aclk);
            #1;
            n++;
        end
        rready = 0;
        if (!done)
            check("timeout_r", 64'(done), 64'd1);
    endtask

    task automatic clear_logs();
        r_log.delete();
        b_log.delete();
        w_beats = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, wa;
        logic [7:0]  rl, wl;
        logic [2:0]  rs, wsz;
        logic [1:0]  rb, wb;
        int          last_at;

        rst = 1; gaps = 0; w_beats = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        repeat (3) @(posedge axi_aclk);
        #1 rst = 0;
        repeat (5) @(posedge axi_aclk);
        @(negedge axi_aclk);
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_bid", bid, '0);
        check("rst_rid", rid, '0);
        check("rst_rdata", rdata, 64'd0);
        @(posedge axi_aclk);
        #1;

        // Fill the whole memory so every later read has a known reference value.
        for (int i = 0; i < 256; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
        end
        do_write(12'h001, 32'h0, 8'd255, 3'd3, 2'b01, 255, 0);

        // INCR write then read of words 2..5.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'hA0 + 64'(i);
            ws[i] = 8'hFF;
        end
        do_write(12'h123, 32'h10, 8'd3, 3'd3, 2'b01, 3, 0);
        check("t1_bcount", b_log.size(), 1);
        check("t1_bid", b_log[0].id, 12'h123);
        check("t1_bresp", b_log[0].resp, 2'b00);
        do_read(12'h456, 32'h10, 8'd3, 3'd3, 2'b01, 0);
        check("t1_rcount", r_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_rdata", r_log[i].data, 64'hA0 + 64'(i));
            check("t1_rlast", r_log[i].last, i == 3);
            check("t1_rresp", r_log[i].resp, 2'b00);
        end

        // FIXED write merging two half-word strobes into word 1.
        clear_logs();
        wd[0] = 64'h1111_1111_1111_1111; ws[0] = 8'h0F;
        wd[1] = 64'h2222_2222_2222_2222; ws[1] = 8'hF0;
        do_write(12'h00A, 32'h8, 8'd1, 3'd3, 2'b00, 1, 0);
        do_read(12'h00B, 32'h8, 8'd0, 3'd3, 2'b01, 0);
        check("t2_bresp", b_log[0].resp, 2'b00);
        check("t2_rdata", r_log[0].data, 64'h2222_2222_1111_1111);
        check("t2_rresp", r_log[0].resp, 2'b00);

        // Out-of-range write and WRAP read.
        clear_logs();
        wd[0] = 64'hDEAD_BEEF_DEAD_BEEF; ws[0] = 8'hFF;
        do_write(12'h00C, LIMIT, 8'd0, 3'd3, 2'b01, 0, 0);
        check("t3_bresp", b_log[0].resp, 2'b11);
        do_read(12'h00D, 32'h10, 8'd1, 3'd3, 2'b10, 0);
        check("t3_rcount", r_log.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check("t3_rdata", r_log[i].data, 64'd0);
            check("t3_rresp", r_log[i].resp, 2'b10);
        end

        // Early wlast: all awlen+1 beats still taken, SLVERR reported, data still written.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
        end
        do_write(12'h00E, 32'h40, 8'd2, 3'd3, 2'b01, 1, 0);
        check("t4_wbeats", w_beats, 3);
        check("t4_bresp", b_log[0].resp, 2'b10);
        do_read(12'h00F, 32'h40, 8'd2, 3'd3, 2'b01, 0);

        // Concurrent access to word 0: toggling rready, bready held off.
        clear_logs();
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        wd[1] = {$urandom, $urandom}; ws[1] = 8'h3C;
        fork
            do_write(12'h0AA, 32'h0, 8'd1, 3'd3, 2'b00, 1, 4);
            do_read(12'h0BB, 32'h0, 8'd3, 3'd3, 2'b00, 1);
        join
        check("t5_bresp", b_log[0].resp, 2'b00);
        check("t5_rcount", r_log.size(), 4);
        check("t5_rlast", r_log[3].last, 1'b1);

        // Randomized concurrent traffic.
        gaps = 1;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 8; i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'($urandom);
            end
            wb  = ($urandom_range(0, 9) < 5) ? 2'b01 : ($urandom_range(0, 3) == 0 ? 2'($urandom_range(2, 3)) : 2'b00);
            rb  = ($urandom_range(0, 9) < 5) ? 2'b01 : ($urandom_range(0, 3) == 0 ? 2'($urandom_range(2, 3)) : 2'b00);
            wsz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rs  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            wl  = 8'($urandom_range(0, 7));
            rl  = 8'($urandom_range(0, 7));
            wa  = wb[1] ? $urandom_range(0, 1023) : $urandom_range(0, 2300);
            ra  = rb[1] ? $urandom_range(0, 1023) : $urandom_range(0, 2300);
            last_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : int'(wl);
            fork
                do_write(12'($urandom), wa, wl, wsz, wb, last_at, int'($urandom_range(0, 3)));
                do_read(12'($urandom), ra, rl, rs, rb, 2);
            join
        end
        repeat (3) @(posedge axi_aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
